zet_rep_sequencer: RTL
======================

Name: zet_rep_sequencer

Overview:
Sequential controller for 8086/186 string instructions with and without REP/REPZ/REPNZ prefixes. It latches the prefix, opcode and count register on `start`, then issues one `iter_go` strobe per iteration to the exec datapath. It maintains its own count copy and decides when to stop: count exhausted, ZF termination (CMPS/SCAS) or a pending external interrupt. It sits between the fetch FSM and exec, and generalises the combinational next-state helper to configurable count width and interrupt-poll interval.

Parameters:
CNT_W, 16, width of the repeat count (16 = CX, 32 = ECX).
INT_POLL, 1, ext_int is sampled only after every INT_POLL-th completed iteration (1..255).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse: string instruction decoded; ignored unless busy=0
prefix  in  2  [1]=rep present, [0]=1 repz / 0 repnz; sampled on start
opcode  in  7  opcode[7:1]; sampled on start
cnt_in  in  CNT_W  CX/ECX value; sampled on start
iter_done  in  1  exec finished current iteration (one-cycle pulse)
zf  in  1  zero flag, valid in the cycle iter_done=1
ext_int  in  1  level, pending maskable interrupt
busy  out  1  sequencer active
iter_go  out  1  one-cycle pulse: run one iteration
cnt_q  out  CNT_W  current count, written back to CX by exec
done  out  1  one-cycle pulse: instruction finished
exit_rsn  out  2  valid with done: 0 single/non-rep, 1 count zero, 2 ZF exit, 3 interrupt
use_eintp  out  1  valid with done: 1 = return IP must point at the prefix (exit_rsn=3)

Behaviour:
- Reset (asynchronous, any state): state IDLE; busy, iter_go, done, use_eintp = 0; exit_rsn = 0; cnt_q = 0; poll counter = 0.
- Decodes:
  - valid_ops = opcode is one of 1010010, 1010011, 1010101, 0110110, 0110111, 1010110, 1010111.
  - cmp_sca = opcode[7] & opcode[2] & opcode[1].
  - rep_mode = prefix[1] & valid_ops. Prefix and opcode are held in registers after start.
- IDLE: on start, latch the inputs, load cnt_q = cnt_in, clear the poll counter, set busy=1. Next state is CHECK if rep_mode, else ITER.
- CHECK (rep_mode only), one cycle. Priority order:
  1. cnt_q==0 -> DONE, rsn 1.
  2. Else ext_int=1 and poll counter==0 -> DONE, rsn 3.
  3. Else -> ITER.
- ITER: assert iter_go for exactly one cycle, then go to WAIT.
- WAIT: hold until iter_done; iter_done in any other state is ignored.
  - Non-rep: on iter_done -> DONE, rsn 0; cnt_q unchanged.
  - Rep: on iter_done, cnt_q <= cnt_q-1 (modulo 2^CNT_W). poll counter <= (poll==INT_POLL-1) ? 0 : poll+1.
  - If cmp_sca and (prefix[0] ? ~zf : zf) -> DONE, rsn 2.
  - Else -> CHECK.
- DONE: for one cycle, done=1, exit_rsn and use_eintp valid, busy=1; then IDLE with busy=0. use_eintp=1 iff rsn=3.
- Latency:
  - start to first iter_go: 2 cycles for rep, 1 cycle for non-rep.
  - iter_done to next iter_go: 2 cycles.
  - cnt_zero at start to done: 2 cycles.
- ZF exit takes priority over count zero: a REPZ CMPS whose last iteration mismatches reports rsn 2 with cnt_q=0.
- Non-string opcode with a rep prefix is treated as non-rep (exactly one iteration).
- start while busy=1 is ignored. ext_int outside CHECK is ignored.

Decomposition:
- Package zet_rep_pkg:
  - state enum IDLE/CHECK/ITER/WAIT/DONE;
  - exit-reason constants RSN_SINGLE/RSN_CNT0/RSN_ZF/RSN_INT;
  - string-opcode constants.
- One natural sub-module: zet_rep_decode (combinational valid_ops/cmp_sca/exit_z from the latched prefix and opcode).

Test Plan:
- REP MOVSB (prefix=10, opcode=1010010), cnt_in=3, ext_int=0, iter_done 1 cycle after each iter_go -> 3 iter_go pulses; cnt_q 2,1,0; done with rsn 1, use_eintp=0.
- REP STOSB with cnt_in=0 -> no iter_go; done 2 cycles after start, rsn 1, cnt_q=0.
- REPZ CMPSB (prefix=11, opcode=1010011), cnt_in=5, zf=1,1,0 -> 3 iterations; done rsn 2; cnt_q=2.
- REPNZ SCASB (prefix=10, opcode=1010111), cnt_in=4, ext_int raised after the 2nd iter_done, INT_POLL=1 -> done rsn 3, use_eintp=1, cnt_q=2. Repeat with INT_POLL=4 -> runs to cnt_q=0, rsn 1.
- Non-rep LODSB (prefix=00), and rep with non-string opcode 1000100 -> exactly 1 iter_go; rsn 0; cnt_q unchanged. CNT_W=32 with cnt_in=0x0001_0000 -> first decrement gives 0x0000_FFFF.
- Assert rst while in WAIT -> outputs zero immediately (asynchronous); a stray later iter_done produces no done; a new start proceeds normally.

Source files
------------

// File: rtl/zet_rep_pkg.sv
// Shared types and constants for the string-instruction repeat sequencer.
package zet_rep_pkg;

    localparam int unsigned OP_W   = 7;
    localparam int unsigned RSN_W  = 2;
    localparam int unsigned POLL_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ITER,
        WAIT,
        DONE
    } state_t;

    localparam logic [RSN_W-1:0] RSN_SINGLE = 2'd0;
    localparam logic [RSN_W-1:0] RSN_CNT0   = 2'd1;
    localparam logic [RSN_W-1:0] RSN_ZF     = 2'd2;
    localparam logic [RSN_W-1:0] RSN_INT    = 2'd3;

    // Opcode bits [7:1] of the repeatable string instructions.
    localparam logic [OP_W-1:0] OP_MOVS = 7'b1010010;
    localparam logic [OP_W-1:0] OP_CMPS = 7'b1010011;
    localparam logic [OP_W-1:0] OP_STOS = 7'b1010101;
    localparam logic [OP_W-1:0] OP_INS  = 7'b0110110;
    localparam logic [OP_W-1:0] OP_OUTS = 7'b0110111;
    localparam logic [OP_W-1:0] OP_LODS = 7'b1010110;
    localparam logic [OP_W-1:0] OP_SCAS = 7'b1010111;

endpackage

// File: rtl/zet_rep_decode.sv
// Combinational decode of prefix/opcode: repeat mode, compare class and ZF exit test.
module zet_rep_decode
    import zet_rep_pkg::*;
(
    input  logic [1:0] prefix,
    input  logic [7:1] opcode,
    input  logic       zf,
    output logic       valid_ops_c,
    output logic       cmp_sca_c,
    output logic       rep_mode_c,
    output logic       exit_z_c
);

    always_comb begin
        valid_ops_c = 1'b0;
        case (opcode)
            OP_MOVS, OP_CMPS, OP_STOS, OP_INS,
            OP_OUTS, OP_LODS, OP_SCAS: valid_ops_c = 1'b1;
            default:                   valid_ops_c = 1'b0;
        endcase
    end

    assign cmp_sca_c  = opcode[7] & opcode[2] & opcode[1];
    assign rep_mode_c = prefix[1] & valid_ops_c;
    // REPZ stops on a mismatch (zf=0), REPNZ stops on a match (zf=1).
    assign exit_z_c   = cmp_sca_c & (prefix[0] ? ~zf : zf);

endmodule

// File: rtl/zet_rep_sequencer.sv
// Iteration controller for (REP-prefixed) string instructions between fetch and exec.
module zet_rep_sequencer
    import zet_rep_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned INT_POLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       prefix,
    input  logic [7:1]       opcode,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             iter_done,
    input  logic             zf,
    input  logic             ext_int,
    output logic             busy,
    output logic             iter_go,
    output logic [CNT_W-1:0] cnt_q,
    output logic             done,
    output logic [1:0]       exit_rsn,
    output logic             use_eintp
);

    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(INT_POLL - 1);

    state_t            state, state_d;
    logic [1:0]        prefix_q;
    logic [7:1]        opcode_q;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [CNT_W-1:0]  cnt_d;
    logic [1:0]        exit_rsn_d;
    logic              use_eintp_d;
    logic              load;

    logic [1:0]        dec_prefix;
    logic [7:1]        dec_opcode;
    logic              valid_ops_c, cmp_sca_c, rep_mode_c, exit_z_c;

    // In IDLE the decision must come from the live inputs; afterwards from the latched copy.
    assign dec_prefix = (state == IDLE) ? prefix : prefix_q;
    assign dec_opcode = (state == IDLE) ? opcode : opcode_q;

    zet_rep_decode u_decode (
        .prefix      (dec_prefix),
        .opcode      (dec_opcode),
        .zf          (zf),
        .valid_ops_c (valid_ops_c),
        .cmp_sca_c   (cmp_sca_c),
        .rep_mode_c  (rep_mode_c),
        .exit_z_c    (exit_z_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt_q;
        poll_d     = poll_q;
        exit_rsn_d = exit_rsn;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = cnt_in;
                    poll_d  = '0;
                    state_d = rep_mode_c ? CHECK : ITER;
                end
            end
            CHECK: begin
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    exit_rsn_d = RSN_CNT0;
                end else if (ext_int && (poll_q == '0)) begin
                    state_d    = DONE;
                    exit_rsn_d = RSN_INT;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: state_d = WAIT;
            WAIT: begin
                if (iter_done) begin
                    if (!rep_mode_c) begin
                        state_d    = DONE;
                        exit_rsn_d = RSN_SINGLE;
                    end else begin
                        cnt_d  = cnt_q - CNT_W'(1);
                        poll_d = (poll_q == POLL_LAST) ? '0 : poll_q + POLL_W'(1);
                        if (exit_z_c) begin
                            state_d    = DONE;
                            exit_rsn_d = RSN_ZF;
                        end else begin
                            state_d = CHECK;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        use_eintp_d = (state_d == DONE) ? (exit_rsn_d == RSN_INT) : use_eintp;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prefix_q  <= '0;
            opcode_q  <= '0;
            poll_q    <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            iter_go   <= 1'b0;
            done      <= 1'b0;
            exit_rsn  <= RSN_SINGLE;
            use_eintp <= 1'b0;
        end else begin
            state     <= state_d;
            poll_q    <= poll_d;
            cnt_q     <= cnt_d;
            busy      <= (state_d != IDLE);
            iter_go   <= (state_d == ITER);
            done      <= (state_d == DONE);
            exit_rsn  <= exit_rsn_d;
            use_eintp <= use_eintp_d;
            if (load) begin
                prefix_q <= prefix;
                opcode_q <= opcode;
            end
        end
    end

endmodule
